// File: rtl/preg_alloc_ckpt_pkg.sv
// preg_alloc_ckpt_pkg: shared sizes, index types and reset map for the physical-register manager
package preg_alloc_ckpt_pkg;
  localparam int NUM_PREGS_D = 64;
  localparam int NUM_AREGS_D = 32;
  localparam int ALLOC_W_D   = 3;
  localparam int CMPL_W_D    = 3;
  localparam int RET_W_D     = 3;
  localparam int NUM_CKPT_D  = 4;
  localparam int PB_D        = $clog2(NUM_PREGS_D);
  localparam int CB_D        = $clog2(NUM_CKPT_D);
  typedef logic [PB_D-1:0] preg_idx_t;
  typedef logic [CB_D-1:0] ckpt_id_t;
  localparam logic [NUM_PREGS_D-1:0] RESET_FREE = {{(NUM_PREGS_D-NUM_AREGS_D){1'b1}}, {NUM_AREGS_D{1'b0}}};
endpackage

// File: rtl/preg_alloc_ckpt_select.sv
// preg_select: picks the ALLOC_W lowest free registers and gates how many may be taken
//   free_vec/free_count in, squash forces alloc_avail to 0, alloc_idx slot i = i-th lowest free bit
module preg_select import preg_alloc_ckpt_pkg::*; #(
  parameter int NUM_PREGS = NUM_PREGS_D,
  parameter int ALLOC_W   = ALLOC_W_D,
  parameter int PB        = $clog2(NUM_PREGS),
  parameter int AB        = $clog2(ALLOC_W+1),
  parameter int FB        = $clog2(NUM_PREGS+1)
)(
  input  logic [NUM_PREGS-1:0]  free_vec,
  input  logic [FB-1:0]         free_count,
  input  logic                  squash,
  output logic [ALLOC_W*PB-1:0] alloc_idx,
  output logic [AB-1:0]         alloc_avail
);
  logic [NUM_PREGS-1:0] m;
  logic [PB-1:0]        sel;
  always_comb begin
    m = free_vec;
    alloc_idx = '0;
    sel = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      sel = '0;
      for (int b = NUM_PREGS-1; b >= 0; b--) if (m[b]) sel = PB'(b);
      alloc_idx[i*PB+:PB] = m[sel] ? sel : '0;
      m[sel] = 1'b0;
    end
    alloc_avail = squash ? '0 : (free_count < FB'(ALLOC_W) ? AB'(free_count) : AB'(ALLOC_W));
  end
endmodule

// File: rtl/preg_alloc_ckpt.sv
// preg_alloc_ckpt: free/ready lists, multi-wide allocation and branch checkpoints of the free list
//   dispatch: alloc_count/alloc_avail/alloc_idx; CDB: cmpl_*; retire: ret_*; branches: ckpt_*, br_*
//   outputs free_vec, ready_vec and registered free_count
module preg_alloc_ckpt import preg_alloc_ckpt_pkg::*; #(
  parameter int NUM_PREGS = NUM_PREGS_D,
  parameter int NUM_AREGS = NUM_AREGS_D,
  parameter int ALLOC_W   = ALLOC_W_D,
  parameter int CMPL_W    = CMPL_W_D,
  parameter int RET_W     = RET_W_D,
  parameter int NUM_CKPT  = NUM_CKPT_D,
  localparam int PB = $clog2(NUM_PREGS),
  localparam int CB = $clog2(NUM_CKPT),
  localparam int AB = $clog2(ALLOC_W+1),
  localparam int FB = $clog2(NUM_PREGS+1)
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [AB-1:0]         alloc_count,
  output logic [AB-1:0]         alloc_avail,
  output logic [ALLOC_W*PB-1:0] alloc_idx,
  input  logic [CMPL_W-1:0]     cmpl_valid,
  input  logic [CMPL_W*PB-1:0]  cmpl_idx,
  input  logic [RET_W-1:0]      ret_valid,
  input  logic [RET_W*PB-1:0]   ret_idx,
  input  logic                  ckpt_take,
  output logic [CB-1:0]         ckpt_take_id,
  output logic                  ckpt_full,
  input  logic                  br_valid,
  input  logic [CB-1:0]         br_id,
  input  logic                  br_mispredict,
  output logic [NUM_PREGS-1:0]  free_vec,
  output logic [NUM_PREGS-1:0]  ready_vec,
  output logic [FB-1:0]         free_count
);
  localparam logic [NUM_PREGS-1:0] RST_FREE = {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
  logic [NUM_PREGS-1:0] free_q, free_d, ready_q, ready_d, a_mask, r_mask, c_mask;
  logic [NUM_PREGS-1:0] ckpt_free_q [NUM_CKPT];
  logic [NUM_PREGS-1:0] ckpt_free_d [NUM_CKPT];
  logic [NUM_CKPT-1:0]  older_q [NUM_CKPT];
  logic [NUM_CKPT-1:0]  older_d [NUM_CKPT];
  logic [NUM_CKPT-1:0]  valid_q, valid_d, res_mask, kill;
  logic [FB-1:0]        free_count_q, free_count_d;
  logic [AB-1:0]        n_alloc;
  logic                 mp, restore, cres, take_ok;
  preg_select #(.NUM_PREGS(NUM_PREGS), .ALLOC_W(ALLOC_W), .PB(PB), .AB(AB), .FB(FB)) u_sel (
    .free_vec(free_q), .free_count(free_count_q), .squash(mp),
    .alloc_idx(alloc_idx), .alloc_avail(alloc_avail)
  );
  always_comb begin
    ckpt_take_id = '0;
    for (int j = NUM_CKPT-1; j >= 0; j--) if (!valid_q[j]) ckpt_take_id = CB'(j);
    ckpt_full = &valid_q;
    n_alloc = alloc_count > alloc_avail ? alloc_avail : alloc_count;
    a_mask = '0;
    r_mask = '0;
    c_mask = '0;
    for (int i = 0; i < ALLOC_W; i++) if (AB'(i) < n_alloc) a_mask[alloc_idx[i*PB+:PB]] = 1'b1;
    for (int i = 0; i < RET_W; i++) if (ret_valid[i]) r_mask[ret_idx[i*PB+:PB]] = 1'b1;
    for (int i = 0; i < CMPL_W; i++) if (cmpl_valid[i]) c_mask[cmpl_idx[i*PB+:PB]] = 1'b1;
    mp = br_valid & br_mispredict;
    restore = mp & valid_q[br_id];
    cres = br_valid & ~br_mispredict & valid_q[br_id];
    res_mask = cres ? (NUM_CKPT'(1) << br_id) : '0;
    take_ok = ckpt_take & ~ckpt_full & ~mp;
    // a mispredict also kills every younger checkpoint that recorded br_id as older
    kill = '0;
    if (restore) begin
      kill[br_id] = 1'b1;
      for (int j = 0; j < NUM_CKPT; j++) if (older_q[j][br_id]) kill[j] = 1'b1;
    end
    free_d = restore ? (ckpt_free_q[br_id] | r_mask) : ((free_q & ~a_mask) | r_mask);
    ready_d = (ready_q & ~a_mask) | c_mask;
    valid_d = valid_q & ~res_mask & ~kill;
    for (int j = 0; j < NUM_CKPT; j++) begin
      ckpt_free_d[j] = ckpt_free_q[j] | r_mask;
      older_d[j] = older_q[j] & ~res_mask;
    end
    // take_id comes from the pre-resolve valid mask, so a slot freed this cycle is not reused yet
    if (take_ok) begin
      valid_d[ckpt_take_id] = 1'b1;
      ckpt_free_d[ckpt_take_id] = (free_q & ~a_mask) | r_mask;
      older_d[ckpt_take_id] = valid_q & ~res_mask;
    end
    free_count_d = FB'($countones(free_d));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_q <= RST_FREE;
      ready_q <= ~RST_FREE;
      free_count_q <= FB'(NUM_PREGS-NUM_AREGS);
      valid_q <= '0;
      for (int j = 0; j < NUM_CKPT; j++) begin
        ckpt_free_q[j] <= '0;
        older_q[j] <= '0;
      end
    end else begin
      free_q <= free_d;
      ready_q <= ready_d;
      free_count_q <= free_count_d;
      valid_q <= valid_d;
      for (int j = 0; j < NUM_CKPT; j++) begin
        ckpt_free_q[j] <= ckpt_free_d[j];
        older_q[j] <= older_d[j];
      end
    end
  end
  always @(posedge clock) begin
    if (!reset) begin
      assert (alloc_count <= alloc_avail) else $warning("alloc_count %0d above alloc_avail %0d", alloc_count, alloc_avail);
      assert (!(ckpt_take && ckpt_full && !mp)) else $warning("checkpoint take while all checkpoints valid");
      assert (!br_valid || valid_q[br_id]) else $warning("branch resolve on invalid checkpoint %0d", br_id);
      assert ((a_mask & c_mask) == '0) else $warning("completion on a register allocated this cycle");
    end
  end
  assign free_vec = free_q;
  assign ready_vec = ready_q;
  assign free_count = free_count_q;
endmodule

// File: tb/tb_preg_alloc_ckpt.sv
// tb_preg_alloc_ckpt: directed stimulus with a scoreboard queue drained by a negedge monitor
module tb_preg_alloc_ckpt;
  logic        clock = 1'b0, reset = 1'b1;
  logic [1:0]  alloc_count, alloc_avail, br_id, ckpt_take_id;
  logic [17:0] alloc_idx, cmpl_idx, ret_idx;
  logic [2:0]  cmpl_valid, ret_valid;
  logic        ckpt_take, ckpt_full, br_valid, br_mispredict;
  logic [63:0] free_vec, ready_vec;
  logic [6:0]  free_count;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int due; int kind; logic [63:0] exp; string name;} exp_t;
  exp_t sb[$];
  localparam logic [63:0] RF = {{32{1'b1}}, {32{1'b0}}};
  logic [63:0] ef, er, snap;
  preg_alloc_ckpt dut (
    .clock(clock), .reset(reset), .alloc_count(alloc_count), .alloc_avail(alloc_avail),
    .alloc_idx(alloc_idx), .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .ret_valid(ret_valid),
    .ret_idx(ret_idx), .ckpt_take(ckpt_take), .ckpt_take_id(ckpt_take_id), .ckpt_full(ckpt_full),
    .br_valid(br_valid), .br_id(br_id), .br_mispredict(br_mispredict), .free_vec(free_vec),
    .ready_vec(ready_vec), .free_count(free_count)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic logic [63:0] obs(int k);
    case (k)
      0: return free_vec;
      1: return ready_vec;
      2: return 64'(free_count);
      3: return 64'(alloc_avail);
      4: return 64'(alloc_idx);
      5: return 64'(ckpt_take_id);
      default: return 64'(ckpt_full);
    endcase
  endfunction
  function automatic logic [63:0] pk(int a, int b, int c);
    logic [17:0] v;
    v = {6'(c), 6'(b), 6'(a)};
    return 64'(v);
  endfunction
  task automatic push(int d, int k, logic [63:0] e, string n);
    sb.push_back('{d, k, e, n});
  endtask
  always @(negedge clock) begin
    for (int i = 0; i < sb.size();) begin
      if (sb[i].due <= cyc) begin
        checks++;
        if (obs(sb[i].kind) !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %0h, expected %0h", sb[i].name, obs(sb[i].kind), sb[i].exp);
        end
        sb.delete(i);
      end else i++;
    end
  end
  task automatic idle();
    alloc_count = 0; cmpl_valid = 0; cmpl_idx = 0; ret_valid = 0; ret_idx = 0;
    ckpt_take = 0; br_valid = 0; br_id = 0; br_mispredict = 0;
  endtask
  task automatic nxt();
    @(posedge clock);
    #1;
    idle();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    push(cyc, 0, RF, "rst_free"); push(cyc, 1, ~RF, "rst_ready"); push(cyc, 2, 32, "rst_count");
    push(cyc, 3, 3, "rst_avail"); push(cyc, 6, 0, "rst_full"); push(cyc, 5, 0, "rst_take_id");
    // 1: first allocation
    alloc_count = 3;
    push(cyc, 4, pk(32, 33, 34), "t1_idx");
    ef = RF & ~(64'h7 << 32); er = ~RF & ~(64'h7 << 32);
    push(cyc+1, 0, ef, "t1_free"); push(cyc+1, 1, er, "t1_ready"); push(cyc+1, 2, 29, "t1_count");
    // 2: complete 33, retire 5
    nxt();
    cmpl_valid = 3'b001; cmpl_idx = 18'(33); ret_valid = 3'b001; ret_idx = 18'(5);
    ef |= 64'd1 << 5; er |= 64'd1 << 33;
    push(cyc+1, 0, ef, "t2_free"); push(cyc+1, 1, er, "t2_ready"); push(cyc+1, 2, 30, "t2_count");
    // 3: checkpoint, allocate past it, retire, mispredict
    nxt();
    alloc_count = 1; ckpt_take = 1;
    push(cyc, 4, pk(5, 35, 36), "t3_idx_a"); push(cyc, 5, 0, "t3_take_id");
    ef &= ~(64'd1 << 5); er &= ~(64'd1 << 5); snap = ef;
    push(cyc+1, 0, ef, "t3_free_a"); push(cyc+1, 2, 29, "t3_count_a"); push(cyc+1, 5, 1, "t3_take_id_a");
    nxt();
    alloc_count = 2; ret_valid = 3'b010; ret_idx = 18'(7) << 6;
    push(cyc, 4, pk(35, 36, 37), "t3_idx_b");
    ef = (ef & ~(64'h3 << 35)) | (64'd1 << 7);
    push(cyc+1, 0, ef, "t3_free_b"); push(cyc+1, 2, 28, "t3_count_b");
    nxt();
    br_valid = 1; br_id = 0; br_mispredict = 1; alloc_count = 1;
    push(cyc, 3, 0, "t3_avail_mp");
    ef = snap | (64'd1 << 7);
    push(cyc+1, 0, ef, "t3_free_mp"); push(cyc+1, 1, er, "t3_ready_mp"); push(cyc+1, 2, 30, "t3_count_mp");
    push(cyc+1, 5, 0, "t3_take_id_mp");
    // 4: three checkpoints, correct-resolve 1, mispredict 0 kills 2 as well
    for (int k = 0; k < 3; k++) begin
      nxt();
      ckpt_take = 1;
      push(cyc, 5, 64'(k), "t4_take_id");
    end
    nxt();
    br_valid = 1; br_id = 1;
    push(cyc+1, 5, 1, "t4_take_id_res");
    nxt();
    br_valid = 1; br_id = 0; br_mispredict = 1;
    push(cyc+1, 5, 0, "t4_take_id_mp"); push(cyc+1, 6, 0, "t4_full_mp"); push(cyc+1, 0, ef, "t4_free_mp");
    // 5: fill all, take while full, resolve+take same cycle
    for (int k = 0; k < 4; k++) begin
      nxt();
      ckpt_take = 1;
      push(cyc, 5, 64'(k), "t5_take_id");
    end
    push(cyc+1, 6, 1, "t5_full");
    nxt();
    ckpt_take = 1;
    push(cyc+1, 6, 1, "t5_full_ign"); push(cyc+1, 0, ef, "t5_free_ign");
    nxt();
    br_valid = 1; br_id = 2; ckpt_take = 1;
    push(cyc+1, 6, 0, "t5_full_res"); push(cyc+1, 5, 2, "t5_take_id_res");
    nxt();
    ckpt_take = 1;
    push(cyc, 5, 2, "t5_take_id_re"); push(cyc+1, 6, 1, "t5_full_re");
    // 6: drain to two free regs, over-request, then reset mid-burst
    for (int k = 0; k < 9; k++) begin
      nxt();
      alloc_count = 3;
    end
    nxt();
    alloc_count = 1;
    nxt();
    push(cyc, 2, 2, "t6_count"); push(cyc, 3, 2, "t6_avail");
    alloc_count = 3;
    push(cyc, 4, pk(62, 63, 0), "t6_idx");
    push(cyc+1, 2, 0, "t6_count_after"); push(cyc+1, 0, 0, "t6_free_after"); push(cyc+1, 3, 0, "t6_avail_after");
    nxt();
    nxt();
    alloc_count = 3; ret_valid = 3'b001; ret_idx = 18'(9);
    reset = 1'b1;
    #1;
    push(cyc, 0, RF, "t6_rst_free"); push(cyc, 1, ~RF, "t6_rst_ready"); push(cyc, 2, 32, "t6_rst_count");
    push(cyc, 3, 3, "t6_rst_avail"); push(cyc, 6, 0, "t6_rst_full"); push(cyc, 5, 0, "t6_rst_take_id");
    nxt();
    reset = 1'b0;
    push(cyc+1, 0, RF, "t6_post_free");
    repeat (3) nxt();
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
